ntt_address_sequencer: RTL and testbench
========================================

// Module: ntt_address_sequencer
// PURPOSE
//  Address/control initiator for the coefficient-memory address datapaths (address_dp_c0/_c1).
//  Per-cycle it drives the raw address stream plus rdsel/wtsel1/m/s that those blocks
//  pipeline into read/write addresses. Walks all NTT butterfly stages, a bit-reverse pass or
//  a linear copy pass. Sits between the RLWE processor control FSM and the two address datapaths.
// PARAMETERS
//  LOGW   11  log2(memory words); ADDR_W = LOGW, stages per NTT = LOGW
//  DRAIN  16  idle cycles after each stage/pass so the 12-cycle write pipe empties (>=13)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  start        in   1       start pulse; sampled only in IDLE
//  mode         in   2       0 = NTT stages, 1 = bit-reverse pass, 2 = copy pass, 3 = reserved (ignored)
//  hold         in   1       stall: freeze counters and outputs, active_w = 0
//  addressin_w  out  LOGW    raw word address
//  rdsel_w      out  2       read-address select
//  wtsel1_w     out  3       write-address select
//  m_w          out  13      2*half-span; bit 12 flags the final NTT stage
//  s_w          out  4       pass control bits
//  active_w     out  1       slot valid; gates memory read/write enables upstream
//  busy         out  1       high from the cycle after accepted start to done
//  done         out  1       one-cycle pulse at end of operation
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; counters 0. Reset mid-operation aborts at once, no done.
//  All outputs are registered, 1-cycle latency from FSM state.
//  FSM: IDLE -start&mode!=3-> RUN; RUN -last slot of pass-> DRAIN; DRAIN -DRAIN cycles-> next
//   stage RUN (NTT, stage<LOGW-1) or DONE; DONE -> IDLE (done=1 for this one cycle).
//  start while busy and mode==3 are ignored. The mode value is latched at start.
//  NTT mode: stage st=0..LOGW-1, half=2^st, m_w=2*half, m_w[12]=1 only for st==LOGW-1.
//   Butterfly counter c=0..2^(LOGW-1)-1, a = insert a 0 at bit st of c
//   (a = ((c>>st)<<(st+1)) | (c & (half-1))).
//   Each butterfly takes two active slots with addressin_w=a held: slot0 rdsel_w=0, slot1 rdsel_w=1.
//   wtsel1_w=0 (write select follows delayed rdsel), s_w=0.
//   Stage length = 2^LOGW active slots.
//  Bit-reverse mode: addressin_w=0..2^LOGW-1, one per slot, rdsel_w=2, wtsel1_w=2.
//   s_w=4'b0000 (bit-reversed read, pipe3 write). m_w=0. Single pass.
//  Copy mode: addressin_w=0..2^LOGW-1, rdsel_w=3, wtsel1_w=3, s_w=4'b0101, m_w=0. Single pass.
//  DRAIN/IDLE/DONE: active_w=0; addressin_w, rdsel_w, wtsel1_w, s_w and m_w hold their last values.
//   Holding m_w and rdsel_w keeps the downstream write offset stable while the write pipe empties.
//  hold=1 in RUN: active_w=0 that cycle, no counter advance, other outputs unchanged.
//   Resume continues from the same slot (slot0/slot1 phase preserved).
//   hold in DRAIN does not pause the drain count.
//  Wrap: the c and address counters never wrap inside a pass; the last slot triggers DRAIN.
//  Counters return to 0 at the next stage or at start.
//  Cycle count, default NTT: 11 stages*(2048+16)+2 overhead, no hold.
// TESTING
//  LOGW=3, NTT: start -> stage0 addr pairs 0,0,2,2,4,4,6,6 with rdsel 0,1 alternating.
//   m_w=2. Stage2 yields 0,0,1,1,2,2,3,3, m_w=8|4096.
//  LOGW=3, bit-reverse: start -> addressin_w 0..7, rdsel_w=2, wtsel1_w=2, active 8 cycles.
//   Then 16 drain cycles, done pulse exactly once, busy falls with done.
//  hold mid-butterfly (after slot0 of c=1, stage0): outputs frozen, active_w=0.
//   Release -> slot1 same address, rdsel_w=1. Total active count unchanged (8/stage).
//  start during RUN and start with mode=3 in IDLE -> no effect, no busy, no done.
//  rst_n low in stage1 RUN -> all outputs 0 asynchronously, IDLE.
//   Next start restarts at stage0, c=0.
//  Default params, copy mode: 2048 active slots, addresses 0..2047, done 2048+16+2 cycles after start.

Source files
------------

// File: rtl/ntt_address_sequencer.sv
// Address/control initiator for the coefficient-memory address datapaths.
// Walks NTT butterfly stages, a bit-reverse pass or a linear copy pass, with drain gaps.
module ntt_address_sequencer #(
    parameter int LOGW  = 11,
    parameter int DRAIN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic            hold,
    output logic [LOGW-1:0] addressin_w,
    output logic [1:0]      rdsel_w,
    output logic [2:0]      wtsel1_w,
    output logic [12:0]     m_w,
    output logic [3:0]      s_w,
    output logic            active_w,
    output logic            busy,
    output logic            done
);

    localparam int STG_W = $clog2(LOGW + 1);
    localparam int DRN_W = $clog2(DRAIN + 1);
    localparam logic [LOGW-1:0]  C_LAST   = {1'b0, {(LOGW-1){1'b1}}};
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOGW - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'd0,
        MODE_BREV = 2'd1,
        MODE_COPY = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    state_t             r_state;
    state_t             w_state_nxt;
    mode_t              r_mode;
    logic [LOGW-1:0]    r_cnt;
    logic               r_phase;
    logic [STG_W-1:0]   r_stage;
    logic [DRN_W-1:0]   r_drain;

    logic [LOGW-1:0]    r_addr;
    logic [1:0]         r_rdsel;
    logic [2:0]         r_wtsel;
    logic [12:0]        r_m;
    logic [3:0]         r_s;
    logic               r_active;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last_slot;
    logic               w_drain_end;
    logic               w_more_stages;
    logic [LOGW-1:0]    w_low_mask;
    logic [LOGW-1:0]    w_ntt_addr;
    logic [12:0]        w_ntt_m;

    always_comb begin
        w_accept      = start && (mode_t'(mode) != MODE_RSVD);
        w_drain_end   = (r_drain == DRN_LAST);
        w_more_stages = (r_mode == MODE_NTT) && (r_stage != STG_LAST);
        if (r_mode == MODE_NTT) begin
            w_last_slot = r_phase && (r_cnt == C_LAST);
        end else begin
            w_last_slot = (r_cnt == '1);
        end
        // Butterfly index with a zero spliced in at bit 'stage' gives the lower leg address.
        w_low_mask = (LOGW'(1) << r_stage) - LOGW'(1);
        w_ntt_addr = ((r_cnt & ~w_low_mask) << 1) | (r_cnt & w_low_mask);
        w_ntt_m    = (13'd2 << r_stage) | ((r_stage == STG_LAST) ? 13'h1000 : 13'h0000);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (!hold && w_last_slot) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_state_nxt = w_more_stages ? S_RUN : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_NTT;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_stage  <= '0;
            r_drain  <= '0;
            r_addr   <= '0;
            r_rdsel  <= '0;
            r_wtsel  <= '0;
            r_m      <= '0;
            r_s      <= '0;
            r_active <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_active <= (r_state == S_RUN) && !hold;
            // busy stays up through the done cycle so both fall together
            r_busy   <= (w_state_nxt != S_IDLE) || (r_state == S_DONE);
            r_done   <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode  <= mode_t'(mode);
                        r_cnt   <= '0;
                        r_phase <= 1'b0;
                        r_stage <= '0;
                        r_drain <= '0;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        case (r_mode)
                            MODE_NTT: begin
                                r_addr  <= w_ntt_addr;
                                r_rdsel <= {1'b0, r_phase};
                                r_wtsel <= 3'd0;
                                r_m     <= w_ntt_m;
                                r_s     <= 4'b0000;
                            end
                            MODE_BREV: begin
                                r_addr  <= r_cnt;
                                r_rdsel <= 2'd2;
                                r_wtsel <= 3'd2;
                                r_m     <= '0;
                                r_s     <= 4'b0000;
                            end
                            default: begin
                                r_addr  <= r_cnt;
                                r_rdsel <= 2'd3;
                                r_wtsel <= 3'd3;
                                r_m     <= '0;
                                r_s     <= 4'b0101;
                            end
                        endcase
                        if (w_last_slot) begin
                            r_cnt   <= '0;
                            r_phase <= 1'b0;
                        end else if (r_mode == MODE_NTT) begin
                            if (r_phase) begin
                                r_phase <= 1'b0;
                                r_cnt   <= r_cnt + 1'b1;
                            end else begin
                                r_phase <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_end) begin
                        r_drain <= '0;
                        if (w_more_stages) r_stage <= r_stage + 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign addressin_w = r_addr;
    assign rdsel_w     = r_rdsel;
    assign wtsel1_w    = r_wtsel;
    assign m_w         = r_m;
    assign s_w         = r_s;
    assign active_w    = r_active;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_ntt_address_sequencer.sv
// Directed bench: small (LOGW=3) instance for NTT/bit-reverse/hold/reset cases,
// default-size instance for the full copy pass timing.
module tb_ntt_address_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        s_start, s_hold;
    logic [1:0]  s_mode;
    logic [2:0]  s_addr;
    logic [1:0]  s_rdsel;
    logic [2:0]  s_wtsel;
    logic [12:0] s_m;
    logic [3:0]  s_s;
    logic        s_act, s_busy, s_done;

    logic        b_start, b_hold;
    logic [1:0]  b_mode;
    logic [10:0] b_addr;
    logic [1:0]  b_rdsel;
    logic [2:0]  b_wtsel;
    logic [12:0] b_m;
    logic [3:0]  b_s;
    logic        b_act, b_busy, b_done;

    int errors = 0;
    int checks = 0;

    ntt_address_sequencer #(.LOGW(3), .DRAIN(16)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .hold(s_hold),
        .addressin_w(s_addr), .rdsel_w(s_rdsel), .wtsel1_w(s_wtsel), .m_w(s_m),
        .s_w(s_s), .active_w(s_act), .busy(s_busy), .done(s_done)
    );

    ntt_address_sequencer #(.LOGW(11), .DRAIN(16)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .hold(b_hold),
        .addressin_w(b_addr), .rdsel_w(b_rdsel), .wtsel1_w(b_wtsel), .m_w(b_m),
        .s_w(b_s), .active_w(b_act), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the sample showing slot0 of a butterfly; leaves one sample past slot1.
    task automatic ntt_pair(input string tag, input int a, input int m);
        chk({tag, " act0"}, 32'(s_act), 1);
        chk({tag, " addr0"}, 32'(s_addr), a);
        chk({tag, " rdsel0"}, 32'(s_rdsel), 0);
        chk({tag, " m"}, 32'(s_m), m);
        @(negedge clk);
        chk({tag, " act1"}, 32'(s_act), 1);
        chk({tag, " addr1"}, 32'(s_addr), a);
        chk({tag, " rdsel1"}, 32'(s_rdsel), 1);
        chk({tag, " wtsel"}, 32'(s_wtsel), 0);
        chk({tag, " s"}, 32'(s_s), 0);
        @(negedge clk);
    endtask

    task automatic wait_active(input string tag, output int gap);
        gap = 0;
        while (!s_act && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        chk({tag, " reached"}, 32'(s_act), 1);
    endtask

    initial begin
        int gap, d, dcnt, done_at, busy_at_done, busy_after, seen;
        int cyc, nact, bad, done_cyc;

        rst_n = 1'b0;
        s_start = 1'b0; s_hold = 1'b0; s_mode = 2'd0;
        b_start = 1'b0; b_hold = 1'b0; b_mode = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst addr", 32'(s_addr), 0);
        chk("rst act", 32'(s_act), 0);
        chk("rst busy", 32'(s_busy), 0);
        chk("rst done", 32'(s_done), 0);
        chk("rst m", 32'(s_m), 0);
        chk("rst big busy", 32'(b_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // NTT on LOGW=3 with a one-cycle hold after slot0 of c=1 in stage0
        s_mode = 2'd0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("ntt busy", 32'(s_busy), 1);
        chk("ntt act lat", 32'(s_act), 0);
        @(negedge clk);
        ntt_pair("st0 c0", 0, 2);
        chk("st0 c1 act0", 32'(s_act), 1);
        chk("st0 c1 addr0", 32'(s_addr), 2);
        chk("st0 c1 rdsel0", 32'(s_rdsel), 0);
        s_hold = 1'b1;
        @(negedge clk);
        chk("hold act", 32'(s_act), 0);
        chk("hold addr", 32'(s_addr), 2);
        chk("hold rdsel", 32'(s_rdsel), 0);
        chk("hold m", 32'(s_m), 2);
        s_hold = 1'b0;
        @(negedge clk);
        chk("resume act", 32'(s_act), 1);
        chk("resume addr", 32'(s_addr), 2);
        chk("resume rdsel", 32'(s_rdsel), 1);
        @(negedge clk);
        ntt_pair("st0 c2", 4, 2);
        ntt_pair("st0 c3", 6, 2);
        chk("drain0 act", 32'(s_act), 0);
        chk("drain0 addr held", 32'(s_addr), 6);
        chk("drain0 rdsel held", 32'(s_rdsel), 1);
        chk("drain0 m held", 32'(s_m), 2);
        wait_active("st1", gap);
        chk("st0 drain gap", gap, 16);
        ntt_pair("st1 c0", 0, 4);
        ntt_pair("st1 c1", 1, 4);
        ntt_pair("st1 c2", 4, 4);
        ntt_pair("st1 c3", 5, 4);
        wait_active("st2", gap);
        chk("st1 drain gap", gap, 16);
        ntt_pair("st2 c0", 0, 4104);
        ntt_pair("st2 c1", 1, 4104);
        ntt_pair("st2 c2", 2, 4104);
        ntt_pair("st2 c3", 3, 4104);
        d = 0;
        while (!s_done && d < 40) begin
            @(negedge clk);
            d++;
        end
        chk("ntt done delay", d, 16);
        chk("ntt busy at done", 32'(s_busy), 1);
        chk("ntt addr held", 32'(s_addr), 3);
        chk("ntt m held", 32'(s_m), 4104);
        @(negedge clk);
        chk("ntt done pulse", 32'(s_done), 0);
        chk("ntt busy fall", 32'(s_busy), 0);

        // Bit-reverse pass, with an ignored start mid-pass
        s_mode = 2'd1; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("brev act", 32'(s_act), 1);
            chk("brev addr", 32'(s_addr), i);
            chk("brev rdsel", 32'(s_rdsel), 2);
            chk("brev wtsel", 32'(s_wtsel), 2);
            chk("brev s", 32'(s_s), 0);
            chk("brev m", 32'(s_m), 0);
            if (i == 3) begin s_mode = 2'd0; s_start = 1'b1; end
            if (i == 4) s_start = 1'b0;
            @(negedge clk);
        end
        dcnt = 0; done_at = -1; busy_at_done = 0; busy_after = 1; seen = 0;
        for (int j = 0; j < 30; j++) begin
            if (s_act) seen++;
            if (s_done) begin
                dcnt++;
                if (done_at < 0) begin done_at = j; busy_at_done = 32'(s_busy); end
            end
            if (done_at >= 0 && j == done_at + 1) busy_after = 32'(s_busy);
            @(negedge clk);
        end
        chk("brev done count", dcnt, 1);
        chk("brev done delay", done_at, 16);
        chk("brev busy at done", busy_at_done, 1);
        chk("brev busy after", busy_after, 0);
        chk("brev no restart", seen, 0);

        // Reserved mode start is ignored
        s_mode = 2'd3; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (s_busy || s_done || s_act) seen++;
        end
        chk("mode3 ignored", seen, 0);

        // Asynchronous reset in stage1 RUN, then restart from stage0
        s_mode = 2'd0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        wait_active("rst st0", gap);
        repeat (8) @(negedge clk);
        wait_active("rst st1", gap);
        chk("rst st1 m", 32'(s_m), 4);
        @(negedge clk);
        chk("rst st1 rdsel", 32'(s_rdsel), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst addr", 32'(s_addr), 0);
        chk("arst rdsel", 32'(s_rdsel), 0);
        chk("arst m", 32'(s_m), 0);
        chk("arst act", 32'(s_act), 0);
        chk("arst busy", 32'(s_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (s_busy || s_done) seen++;
        end
        chk("arst no done", seen, 0);
        s_mode = 2'd0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        @(negedge clk);
        ntt_pair("restart c0", 0, 2);
        ntt_pair("restart c1", 2, 2);

        // Default-size copy pass
        @(negedge clk);
        b_mode = 2'd2; b_start = 1'b1;
        cyc = 0; nact = 0; bad = 0; done_cyc = 0;
        while (done_cyc == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) b_start = 1'b0;
            if (b_act) begin
                if (32'(b_addr) != nact || b_rdsel != 2'd3 || b_wtsel != 3'd3 ||
                    b_s != 4'b0101 || b_m != 13'd0) bad++;
                nact++;
            end
            if (b_done) done_cyc = cyc;
        end
        chk("copy active count", nact, 2048);
        chk("copy slot errors", bad, 0);
        chk("copy done cycle", done_cyc, 2066);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
